// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared widths and miss-handler state encoding
package cache_pkg;

  // Default widths, kept identical to the two-way CLOCK cache
  localparam int ADDR_WIDTH_DEF = 8;
  localparam int LINE_WIDTH_DEF = 32;
  localparam int CNT_WIDTH_DEF  = 16;

  // Miss-handler states; explicit codes keep the encoding stable across tools
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    CHECK  = 3'd2,
    FETCH  = 3'd3,
    FILL   = 3'd4,
    RESP   = 3'd5
  } miss_state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Increment only while below the ceiling so the statistic never rolls over
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Counter register with synchronous clear
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_miss_handler.sv
// rtl/cache_miss_handler.sv - channel-1 read front-end: probe cache, fetch and install on miss
module cache_miss_handler
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int LINE_WIDTH = LINE_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [LINE_WIDTH-1:0] resp_data,
  output logic                  resp_hit,
  output logic [ADDR_WIDTH-1:0] c_addr,
  output logic [LINE_WIDTH-1:0] c_val,
  output logic                  c_read,
  output logic                  c_write,
  input  logic                  c_hit,
  input  logic [LINE_WIDTH-1:0] c_out_val,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [LINE_WIDTH-1:0] mem_data,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  miss_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] data_q, data_d;
  logic                  hit_q, hit_d;
  // Set after the first FILL cycle; c_hit in that first cycle still reflects the miss
  logic                  fill_seen_q, fill_seen_d;
  logic                  inc_hit;
  logic                  inc_miss;

  // Next-state and datapath decode for one outstanding transaction
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    hit_d       = hit_q;
    fill_seen_d = fill_seen_q;
    inc_hit     = 1'b0;
    inc_miss    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (c_hit) begin
          data_d  = c_out_val;
          hit_d   = 1'b1;
          inc_hit = 1'b1;
          state_d = RESP;
        end else begin
          inc_miss = 1'b1;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        if (mem_ack) begin
          data_d      = mem_data;
          hit_d       = 1'b0;
          fill_seen_d = 1'b0;
          state_d     = FILL;
        end
      end
      FILL: begin
        // Keep writing until the cache reports the line present; the cache may
        // need several edges to sweep CLOCK bits before it installs the line
        fill_seen_d = 1'b1;
        if (fill_seen_q && c_hit) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any memory transaction in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      hit_q       <= 1'b0;
      fill_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      hit_q       <= hit_d;
      fill_seen_q <= fill_seen_d;
    end
  end

  // Every output is a decode of registered state so no input reaches an output
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_data  = data_q;
  assign resp_hit   = hit_q;
  assign c_addr     = addr_q;
  assign c_val      = data_q;
  assign c_read     = (state_q == LOOKUP);
  assign c_write    = (state_q == FILL);
  assign mem_req    = (state_q == FETCH);
  assign mem_addr   = addr_q;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (inc_hit),
    .count (hit_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (inc_miss),
    .count (miss_count)
  );

endmodule

// File: tb/tb_cache_miss_handler.sv
// tb/tb_cache_miss_handler.sv - directed bench with cache/memory models and a per-cycle scoreboard
module tb_cache_miss_handler;

  localparam int AW      = 8;
  localparam int LW      = 32;
  localparam int CW      = 2;
  localparam int CNT_MAX = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid, req_ready;
  logic [AW-1:0] req_addr;
  logic          resp_valid, resp_ready;
  logic [LW-1:0] resp_data;
  logic          resp_hit;
  logic [AW-1:0] c_addr;
  logic [LW-1:0] c_val;
  logic          c_read, c_write;
  logic          c_hit;
  logic [LW-1:0] c_out_val;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [LW-1:0] mem_data;
  logic [CW-1:0] hit_count, miss_count;

  int n_checks = 0;
  int n_fail   = 0;

  cache_miss_handler #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_hit(resp_hit),
    .c_addr(c_addr), .c_val(c_val), .c_read(c_read), .c_write(c_write),
    .c_hit(c_hit), .c_out_val(c_out_val),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [LW-1:0] mem_fn(input logic [AW-1:0] a);
    case (a)
      8'h10:   return 32'hDEADBEEF;
      8'h22:   return 32'hCAFEF00D;
      default: return {8'h5A, 8'h00, a, ~a};
    endcase
  endfunction

  function automatic int sat_inc(input int x);
    return (x < CNT_MAX) ? x + 1 : x;
  endfunction

  // Two-line CLOCK cache, registered hit/value, cleared on reset
  logic [AW-1:0] cm_addr [2];
  logic [LW-1:0] cm_val  [2];
  bit            cm_v    [2];
  bit            cm_ref  [2];
  int            cm_hand;

  function automatic int cm_find(input logic [AW-1:0] a);
    for (int i = 0; i < 2; i++) if (cm_v[i] && cm_addr[i] == a) return i;
    return -1;
  endfunction

  always @(posedge clock) begin
    int idx;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin cm_v[i] = 0; cm_ref[i] = 0; cm_addr[i] = '0; cm_val[i] = '0; end
      cm_hand = 0;
      c_hit <= 1'b0;
      c_out_val <= '0;
    end else if (c_read) begin
      idx = cm_find(c_addr);
      if (idx >= 0) begin
        cm_ref[idx] = 1;
        c_hit <= 1'b1;
        c_out_val <= cm_val[idx];
      end else begin
        c_hit <= 1'b0;
        c_out_val <= '0;
      end
    end else if (c_write) begin
      idx = cm_find(c_addr);
      if (idx >= 0) begin
        cm_val[idx] = c_val;
        cm_ref[idx] = 1;
        c_hit <= 1'b1;
        c_out_val <= c_val;
      end else begin
        c_hit <= 1'b0;
        if (cm_v[cm_hand] && cm_ref[cm_hand]) begin
          cm_ref[cm_hand] = 0;
        end else begin
          cm_v[cm_hand] = 1; cm_ref[cm_hand] = 0;
          cm_addr[cm_hand] = c_addr; cm_val[cm_hand] = c_val;
        end
        cm_hand = 1 - cm_hand;
      end
    end
  end

  // Backing memory: ack after mem_lat cycles of mem_req, or one forced pulse
  bit mem_auto = 1;
  bit mem_force = 0;
  int mem_lat = 2;
  int mem_wait = 0;
  initial begin
    mem_ack = 1'b0;
    mem_data = '0;
    forever begin
      @(posedge clock); #1;
      mem_ack = 1'b0;
      if (mem_force) begin
        mem_ack = 1'b1;
        mem_data = mem_fn(8'h40);
        mem_force = 0;
      end else if (mem_auto && mem_req && !reset) begin
        mem_wait++;
        if (mem_wait >= mem_lat) begin
          mem_ack = 1'b1;
          mem_data = mem_fn(mem_addr);
          mem_wait = 0;
        end
      end else begin
        mem_wait = 0;
      end
    end
  end

  // Transaction-level scoreboard, evaluated every cycle away from the edge
  bit            busy = 0, exp_hit = 0, acked = 0, fill_done = 0;
  int            since_acc = 0, ack_since = 0, exp_hits = 0, exp_misses = 0;
  logic [AW-1:0] cur_addr = '0;
  logic [LW-1:0] exp_data = '0;

  always @(negedge clock) begin
    bit exp_rv;
    if (reset) begin
      busy = 0; acked = 0; fill_done = 0; exp_hits = 0; exp_misses = 0; cur_addr = '0;
    end else begin
      if (busy) since_acc++;
      if (acked) ack_since++;
      exp_rv = busy && (exp_hit ? (since_acc >= 3) : fill_done);
      chk("req_ready", 32'(req_ready), 32'(!busy));
      chk("c_addr", 32'(c_addr), 32'(cur_addr));
      chk("c_read", 32'(c_read), 32'(busy && since_acc == 1));
      chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
      chk("mem_req", 32'(mem_req), 32'(busy && !exp_hit && since_acc >= 3 && !acked));
      chk("c_write", 32'(c_write), 32'(busy && !exp_hit && acked && ack_since >= 1 && !fill_done));
      if (mem_req) chk("mem_addr", 32'(mem_addr), 32'(cur_addr));
      if (c_write) chk("c_val", c_val, exp_data);
      if (resp_valid) begin
        chk("resp_data", resp_data, exp_data);
        chk("resp_hit", 32'(resp_hit), 32'(exp_hit));
      end
      if (resp_valid || !busy) begin
        chk("hit_count", 32'(hit_count), 32'(exp_hits));
        chk("miss_count", 32'(miss_count), 32'(exp_misses));
      end
      if (busy) begin
        if (!exp_hit && !acked && since_acc >= 3 && mem_ack) begin acked = 1; ack_since = 0; end
        if (!exp_hit && acked && ack_since >= 2 && c_hit && !fill_done) fill_done = 1;
        if (exp_rv && resp_ready) busy = 0;
      end else if (req_valid) begin
        busy = 1; since_acc = 0; acked = 0; fill_done = 0;
        cur_addr = req_addr;
        exp_hit = (cm_find(req_addr) >= 0);
        exp_data = mem_fn(req_addr);
        if (exp_hit) exp_hits = sat_inc(exp_hits);
        else exp_misses = sat_inc(exp_misses);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic do_req(input logic [AW-1:0] a, input int hold, input bit poke,
                        output int lat, output logic [LW-1:0] d, output logic h,
                        output int fills, output logic [AW-1:0] maddr);
    int guard;
    fills = 0; maddr = '0; guard = 0;
    req_addr = a; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && guard < 200) begin
      if (c_write) fills++;
      if (mem_req) maddr = mem_addr;
      @(posedge clock); #1;
      lat++; guard++;
    end
    if (!resp_valid) begin
      n_checks++; n_fail++;
      $display("FAIL resp_timeout: got no resp_valid expected one within 200 cycles");
    end
    d = resp_data; h = resp_hit;
    for (int i = 0; i < hold; i++) begin
      if (poke && i == 2) begin req_valid = 1'b1; req_addr = 8'h55; end
      @(posedge clock); #1;
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_data", resp_data, d);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    int lat, fills, guard;
    logic [LW-1:0] d;
    logic h;
    logic [AW-1:0] maddr;
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_hit", 32'(resp_hit), 32'd0);
    chk("rst_c_read", 32'(c_read), 32'd0);
    chk("rst_c_write", 32'(c_write), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_c_addr", 32'(c_addr), 32'd0);
    chk("rst_c_val", c_val, 32'd0);
    chk("rst_hit_count", 32'(hit_count), 32'd0);
    chk("rst_miss_count", 32'(miss_count), 32'd0);

    // Warm hit
    do_req(8'h10, 0, 0, lat, d, h, fills, maddr);
    chk("preload_hit", 32'(h), 32'd0);
    chk("preload_data", d, 32'hDEADBEEF);
    do_req(8'h10, 0, 0, lat, d, h, fills, maddr);
    chk("warm_latency", 32'(lat), 32'd3);
    chk("warm_data", d, 32'hDEADBEEF);
    chk("warm_hit", 32'(h), 32'd1);
    chk("warm_hit_count", 32'(hit_count), 32'd1);

    // Cold miss
    mem_lat = 4;
    do_req(8'h22, 0, 0, lat, d, h, fills, maddr);
    chk("cold_mem_addr", 32'(maddr), 32'h22);
    chk("cold_latency", 32'(lat), 32'd10);
    chk("cold_fill_cycles", 32'(fills), 32'd3);
    chk("cold_hit", 32'(h), 32'd0);
    chk("cold_data", d, 32'hCAFEF00D);
    do_req(8'h22, 0, 0, lat, d, h, fills, maddr);
    chk("cold_followup_hit", 32'(h), 32'd1);
    mem_lat = 2;

    // Eviction
    do_reset();
    do_req(8'h01, 0, 0, lat, d, h, fills, maddr);
    do_req(8'h02, 0, 0, lat, d, h, fills, maddr);
    do_req(8'h03, 0, 0, lat, d, h, fills, maddr);
    chk("evict_fill_cycles", 32'(fills), 32'd5);
    chk("evict_data", d, 32'h5A0003FC);
    chk("evict_hit", 32'(h), 32'd0);
    chk("evict_miss_count", 32'(miss_count), 32'd3);

    // Back-pressure with a competing request
    do_req(8'h03, 10, 1, lat, d, h, fills, maddr);
    chk("bp_resp_hit", 32'(h), 32'd1);
    chk("bp_final_data", d, 32'h5A0003FC);

    // Reset mid-FETCH, then a late ack
    mem_auto = 0;
    req_addr = 8'h40; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    guard = 0;
    while (!mem_req && guard < 20) begin @(posedge clock); #1; guard++; end
    repeat (2) begin @(posedge clock); #1; end
    chk("fetch_pending", 32'(mem_req), 32'd1);
    do_reset();
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_hit_count", 32'(hit_count), 32'd0);
    chk("mid_rst_miss_count", 32'(miss_count), 32'd0);
    chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
    chk("mid_rst_c_addr", 32'(c_addr), 32'd0);
    mem_force = 1;
    repeat (5) begin
      @(posedge clock); #1;
      chk("late_ack_c_write", 32'(c_write), 32'd0);
      chk("late_ack_resp_valid", 32'(resp_valid), 32'd0);
      chk("late_ack_req_ready", 32'(req_ready), 32'd1);
    end
    mem_auto = 1;

    // Saturation of the 2-bit hit counter
    do_req(8'h30, 0, 0, lat, d, h, fills, maddr);
    for (int i = 0; i < 5; i++) do_req(8'h30, 0, 0, lat, d, h, fills, maddr);
    chk("sat_hit_count", 32'(hit_count), 32'd3);
    chk("sat_miss_count", 32'(miss_count), 32'd1);

    repeat (3) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
